// File: rtl/stack_pop_seq.sv
// Stack pop sequencer: reads the words selected by a STACK_* pop mask from SS:SP, highest bit first.
// Optional feature macro STACK_POP_PSW_FIXUP_EN forces the fixed PSW bits on a word popped into index 9.
module stack_pop_seq #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       pop_mask,
    input  logic [15:0]       ss,
    input  logic [15:0]       sp_in,
    input  logic [15:0]       imm_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              wr_valid,
    output logic [3:0]        wr_index,
    output logic [15:0]       wr_data,
    output logic [15:0]       sp_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_REQ  = 3'd2,
        S_ADJ  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Wide enough to hold the segment carry before it is cut to ADDR_W bits.
    localparam int SUM_W = (ADDR_W > 21) ? ADDR_W : 21;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [15:0]         mask_r;
    logic [15:0]         ss_r;
    logic [15:0]         imm_r;
    logic [3:0]          cur_r;
    logic [15:0]         sp_r;
    logic                mem_req_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                wr_valid_r;
    logic [3:0]          wr_index_r;
    logic [15:0]         wr_data_r;
    logic                busy_r;
    logic                done_r;
    logic [SUM_W-1:0]    sum_s;
    logic [ADDR_W-1:0]   addr_s;

    // Highest set bit of the remaining read mask; bit 15 is the RET adjust flag, never a read.
    function automatic logic [3:0] top_bit(input logic [14:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

`ifdef STACK_POP_PSW_FIXUP_EN
    // PSW reserved bits: 14:12 and 1 read as one, 5 and 3 read as zero.
    function automatic logic [15:0] psw_fixup(input logic [15:0] d);
        return (d | 16'h7002) & 16'hFFD7;
    endfunction
`endif

    assign sum_s  = SUM_W'({ss_r, 4'h0}) + SUM_W'(sp_r);
    assign addr_s = sum_s[ADDR_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_SCAN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SCAN: begin
                if (mask_r[14:0] == 15'd0) begin
                    state_nxt_s = S_ADJ;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_nxt_s = S_SCAN;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_ADJ:   state_nxt_s = S_DONE;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r     <= 16'h0000;
            ss_r       <= 16'h0000;
            imm_r      <= 16'h0000;
            cur_r      <= 4'd0;
            sp_r       <= 16'h0000;
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
            wr_valid_r <= 1'b0;
            wr_index_r <= 4'd0;
            wr_data_r  <= 16'h0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            wr_valid_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mask_r <= pop_mask;
                        ss_r   <= ss;
                        imm_r  <= imm_in;
                        sp_r   <= sp_in;
                        busy_r <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (mask_r[14:0] != 15'd0) begin
                        cur_r      <= top_bit(mask_r[14:0]);
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= addr_s;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req_r     <= 1'b0;
                        sp_r          <= sp_r + 16'd2;
                        mask_r[cur_r] <= 1'b0;
                        // Index 4 is the SP slot: the word is read to keep SP in step but discarded.
                        if (cur_r != 4'd4) begin
                            wr_valid_r <= 1'b1;
                            wr_index_r <= cur_r;
`ifdef STACK_POP_PSW_FIXUP_EN
                            wr_data_r  <= (cur_r == 4'd9) ? psw_fixup(mem_rdata) : mem_rdata;
`else
                            wr_data_r  <= mem_rdata;
`endif
                        end
                    end
                end
                S_ADJ: begin
                    if (mask_r[15]) begin
                        sp_r <= sp_r + imm_r;
                    end
                    done_r <= 1'b1;
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign wr_valid = wr_valid_r;
    assign wr_index = wr_index_r;
    assign wr_data  = wr_data_r;
    assign sp_out   = sp_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_stack_pop_seq.sv
// Self-checking bench for stack_pop_seq: a scoreboard of expected reads and writes, a memory responder
// with programmable ack delay, and directed sequences including SP wrap, address carry and mid-sequence reset.
module tb_stack_pop_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pop_mask = 16'h0000;
    logic [15:0] ss = 16'h0000;
    logic [15:0] sp_in = 16'h0000;
    logic [15:0] imm_in = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        wr_valid;
    logic [3:0]  wr_index;
    logic [15:0] wr_data;
    logic [15:0] sp_out;
    logic        busy;
    logic        done;

    typedef struct {
        int idx;
        int data;
        int sp;
    } wr_t;

    wr_t wq[$];
    int  aq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  req_cyc = 0;
    int  ack_delay = 0;
    int  data_zero = 0;
    int  start_cyc = 0;
    int  d0 = 0;
    int  exp_sp = 0;

    stack_pop_seq #(.ADDR_W(20)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pop_mask(pop_mask), .ss(ss),
        .sp_in(sp_in), .imm_in(imm_in), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wr_valid(wr_valid), .wr_index(wr_index),
        .wr_data(wr_data), .sp_out(sp_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks each request after ack_delay waiting cycles, checking the address.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && reset_n) begin
                req_cyc++;
                if (wcnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (data_zero != 0) ? 16'h0000 : (16'hA000 + {8'h00, mem_addr[7:0]});
                    check("rd_expected", int'(aq.size() > 0), 1);
                    if (aq.size() > 0) check("rd_addr", mem_addr, aq.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Writeback and done monitor.
    always @(negedge clk) begin
        if (reset_n && wr_valid) begin
            check("wr_expected", int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                wr_t e;
                e = wq.pop_front();
                check("wr_index", wr_index, e.idx);
                check("wr_data", wr_data, e.data);
                check("wr_sp", sp_out, e.sp);
            end
        end
        if (reset_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_seq(input logic [15:0] m, input logic [15:0] s, input logic [15:0] p,
                             input logic [15:0] im);
        int sp;
        int addr;
        int d;
        sp = int'(p);
        for (int b = 14; b >= 0; b--) begin
            if (m[b]) begin
                addr = (int'(s) * 16 + sp) & 32'h000F_FFFF;
                aq.push_back(addr);
                if (b != 4) begin
                    d = (data_zero != 0) ? 0 : (32'hA000 + (addr & 32'hFF));
`ifdef STACK_POP_PSW_FIXUP_EN
                    if (b == 9) d = (d | 32'h7002) & 32'hFFD7;
`endif
                    wq.push_back('{b, d, (sp + 2) & 32'hFFFF});
                end
                sp = (sp + 2) & 32'hFFFF;
            end
        end
        if (m[15]) sp = (sp + int'(im)) & 32'hFFFF;
        exp_sp = sp;
        @(negedge clk);
        pop_mask  = m;
        ss        = s;
        sp_in     = p;
        imm_in    = im;
        start     = 1'b1;
        start_cyc = cyc;
        d0        = done_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_sp_final"}, sp_out, exp_sp);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_wr_left"}, wq.size(), 0);
        check({tag, "_rd_left"}, aq.size(), 0);
        if (exp_lat >= 0) check({tag, "_done_lat"}, done_cyc - start_cyc, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 20'h00000);
        check("rst_wr", {wr_valid, wr_index, wr_data}, 21'd0);
        check("rst_sp_out", sp_out, 16'h0000);
        check("rst_busy_done", {busy, done}, 2'b00);
        reset_n = 1'b1;

        // Eight reads with the SP slot discarded; a second start while busy must be ignored.
        ack_delay = 0;
        start_seq(16'h00FF, 16'h1000, 16'h0100, 16'h0000);
        check("t1_busy", busy, 1'b1);
        pop_mask = 16'hFFFF;
        sp_in    = 16'h5555;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t1", -1);
        check("t1_sp_const", sp_out, 16'h0110);

        // Single PC pop followed by RET-immediate adjust.
        ack_delay = 2;
        start_seq(16'hA000, 16'h1000, 16'h0200, 16'h0006);
        wait_done("t2", -1);
        check("t2_sp_const", sp_out, 16'h0208);

        // Empty mask: no request, done three cycles after start.
        ack_delay = 0;
        r0 = req_cyc;
        start_seq(16'h0000, 16'h1000, 16'h1234, 16'h0055);
        wait_done("t3", 3);
        check("t3_no_req", req_cyc - r0, 0);

        // SP wrap without segment carry, then address carry dropped above 20 bits.
        start_seq(16'h0003, 16'h2000, 16'hFFFE, 16'h0000);
        wait_done("t4", -1);
        check("t4_sp_const", sp_out, 16'h0002);
        start_seq(16'h0001, 16'hFFFF, 16'h0010, 16'h0000);
        wait_done("t5", -1);

        // Reset during a long read wait aborts the sequence without done.
        ack_delay = 5;
        start_seq(16'h0003, 16'h3000, 16'h0400, 16'h0000);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("t6_req_seen", mem_req, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_abort_req", mem_req, 1'b0);
        check("t6_abort_busy", busy, 1'b0);
        check("t6_abort_wr", wr_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        aq.delete();
        wq.delete();
        repeat (8) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_sp_reset", sp_out, 16'h0000);
        ack_delay = 1;
        start_seq(16'h0006, 16'h3000, 16'h0400, 16'h0000);
        wait_done("t6b", -1);

        // PSW pop of a zero word.
        ack_delay = 0;
        data_zero = 1;
        start_seq(16'h0200, 16'h1000, 16'h0300, 16'h0000);
        wait_done("t7", -1);
        data_zero = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_pop_seq.md
Name: stack_pop_seq

Overview:
- Consumes the pre-decoded `pop` mask (same bit encoding as the `STACK_*` constants) and performs the matching stack reads from SS:SP.
- Returns each popped word to the register file / PSW / PC / ModRM writeback path, advances SP by 2 per word, and applies the optional RET-immediate SP adjustment.
- It is the read-side counterpart of the push sequencer and sits between the execute unit and the BIU memory port.

Parameters:
- ADDR_W, 20, physical address width; address = ({ss,4'h0} + {4'h0,sp}) mod 2^ADDR_W.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; accepted only when busy=0
- pop_mask  in  16  `STACK_*`-encoded mask, sampled on accepted start
- ss  in  16  stack segment, sampled on accepted start
- sp_in  in  16  SP at start, sampled on accepted start
- imm_in  in  16  RET adjust, sampled on accepted start; used only if pop_mask[15]
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  ADDR_W  word read address
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  16  read data
- wr_valid  out  1  one-cycle strobe per popped word (not for SP slot)
- wr_index  out  4  mask bit index of the destination (0=AW … 13=PC, 14=MODRM)
- wr_data  out  16  popped value
- sp_out  out  16  running SP, always valid
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, internal mask 0.
- Pop order is highest set bit first, bits 14 down to 0, i.e. the reverse of push order. Bit 15 is never a read.
- States:
  - IDLE: on start, latch inputs, sp_out<=sp_in, busy<=1 → SCAN.
  - SCAN: if the remaining mask[14:0] is zero → ADJ; else select the highest set bit as cur → REQ.
  - REQ: mem_req=1, mem_addr from ss and the current sp_out. Wait for mem_ack.
  - On mem_ack:
    - mem_req<=0; sp_out<=sp_out+2 (mod 2^16); clear bit cur.
    - If cur≠4 (SP slot): wr_valid=1, wr_index=cur, wr_data=mem_rdata in the next cycle.
    - If cur=4, the data is discarded and no write is issued.
    - → SCAN.
  - ADJ: if latched mask[15], sp_out<=sp_out+imm_in (mod 2^16) → DONE.
  - DONE: done=1 for one cycle, busy<=0 → IDLE.
- mem_ack in the same cycle mem_req first asserts is legal: the read is treated as a one-cycle completion.
- mem_ack while not in REQ is ignored.
- start while busy=1 is ignored; there is no queuing.
- pop_mask=0: IDLE→SCAN→ADJ→DONE; done pulses 3 cycles after start; no mem_req.
- Latency per word: 1 SCAN + REQ cycles (≥1) + write cycle overlapped with the next SCAN.
- SP wrap: 0xFFFE+2 → 0x0000. The address is computed with the wrapped SP and the segment is never carried.
- Address carry beyond 2^ADDR_W is dropped, e.g. ss=0xFFFF, sp=0x0010 → 0x00000.
- Reset asserted mid-sequence aborts immediately. mem_req drops asynchronously and no done pulse is issued.

Optional Feature:
- Macro: STACK_POP_PSW_FIXUP_EN.
- When defined, a word popped into index 9 (PSW) has bits [14:12]=1, bit1=1, bits 3 and 5=0 forced before wr_data is driven.
- When undefined, PSW data passes unmodified.
- SP/sequencing is identical in both cases.

Test Plan:
- pop_mask=0x00FF, ss=0x1000, sp_in=0x0100, mem_ack each req with data 0xA000+addr[7:0]:
  - reads at 0x10100..0x1010E.
  - writes index 7,6,5,3,2,1,0; no write for index 4.
  - final sp_out=0x0110.
  - done once.
- pop_mask=0xA000, imm_in=0x0006, sp_in=0x0200:
  - one read, PC write (index 13).
  - sp_out=0x0202 after the read, 0x0208 after ADJ.
- pop_mask=0x0000:
  - no mem_req.
  - done 3 cycles after start.
  - sp_out=sp_in.
- sp_in=0xFFFE, pop_mask=0x0003:
  - first read at {ss,0}+0xFFFE.
  - second read at {ss,0}+0x0000.
  - sp_out=0x0002.
- mem_ack delayed 5 cycles, reset_n pulsed low during wait:
  - mem_req/busy/wr_valid 0 immediately.
  - no done.
  - next start runs normally.
- pop_mask=0x0200 (PSW), mem_rdata=0x0000:
  - wr_data=0x7002 with STACK_POP_PSW_FIXUP_EN, 0x0000 without.
